fir_out_formatter: RTL

//  Downstream output stage of the FIR filter. Captures each signed Y_N_SIZE-bit

---
 rtl/fir_out_formatter_if.sv | 26 ++
 rtl/fir_out_formatter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fir_out_formatter_if.sv
// Sample/byte bus of the FIR output stage: filter-result strobe in, handshaked byte stream out.
// The slave modport is the formatter's view; the master modport is the driving/sinking side.
interface fir_out_formatter_if #(
    parameter int Y_N_SIZE = 11
);
    logic                in_valid;
    logic [Y_N_SIZE-1:0] in_y_n;
    logic                mode;
    logic                out_ready;
    logic                clear_ovf;
    logic [7:0]          out_data;
    logic                out_valid;
    logic                out_last;
    logic                fifo_full;
    logic                overflow;

    modport slave (
        input  in_valid, in_y_n, mode, out_ready, clear_ovf,
        output out_data, out_valid, out_last, fifo_full, overflow
    );

    modport master (
        output in_valid, in_y_n, mode, out_ready, clear_ovf,
        input  out_data, out_valid, out_last, fifo_full, overflow
    );
endinterface

// File: rtl/fir_out_formatter.sv
// FIR output stage: buffers signed results in a small FIFO and streams each one as
// either two bytes (low, sign-extended high) or one saturated byte.
module fir_out_formatter #(
    parameter int Y_N_SIZE   = 11,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    fir_out_formatter_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]          DEPTH_C = FIFO_DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]          ONE_C   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]          ZERO_C  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W-1:0]        PTR1_C  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic signed [Y_N_SIZE-1:0] SAT_HI = Y_N_SIZE'(9'sd127);
    localparam logic signed [Y_N_SIZE-1:0] SAT_LO = Y_N_SIZE'(-9'sd128);

    function automatic logic [7:0] sat8(input logic signed [Y_N_SIZE-1:0] y);
        if (y > SAT_HI) begin
            return 8'h7F;
        end else if (y < SAT_LO) begin
            return 8'h80;
        end else begin
            return y[7:0];
        end
    endfunction

    // Upper byte of the result, sign-extended when the result is narrower than 16 bits.
    function automatic logic [7:0] hi8(input logic signed [Y_N_SIZE-1:0] y);
        return 8'(y >>> 8);
    endfunction

    state_t                state_r, state_next_s;
    logic [Y_N_SIZE-1:0]   mem_r [FIFO_DEPTH];
    logic [ADDR_W-1:0]     wr_ptr_r, rd_ptr_r;
    logic [ADDR_W:0]       count_r, count_next_s;
    logic [Y_N_SIZE-1:0]   hold_y_r, hold_y_next_s;
    logic                  hold_mode_r, hold_mode_next_s;
    logic [7:0]            out_data_r, out_data_next_s;
    logic                  out_valid_r, out_valid_next_s;
    logic                  out_last_r, out_last_next_s;
    logic                  fifo_full_r, overflow_r;
    logic                  xfer_s, pop_s, push_s, drop_s, load_s;
    logic [Y_N_SIZE-1:0]   load_y_s;

    assign xfer_s = out_valid_r & bus.out_ready;
    assign push_s = bus.in_valid & (~fifo_full_r | pop_s);
    assign drop_s = bus.in_valid & fifo_full_r & ~pop_s;

    // Beat sequencing; the outputs are computed here one cycle ahead and registered.
    always_comb begin
        state_next_s     = state_r;
        hold_y_next_s    = hold_y_r;
        hold_mode_next_s = hold_mode_r;
        out_data_next_s  = out_data_r;
        out_valid_next_s = out_valid_r;
        out_last_next_s  = out_last_r;
        pop_s            = 1'b0;
        load_s           = 1'b0;
        load_y_s         = mem_r[rd_ptr_r];
        case (state_r)
            IDLE: begin
                if (count_r != ZERO_C) begin
                    load_s = 1'b1;
                end else begin
                    out_valid_next_s = 1'b0;
                    out_last_next_s  = 1'b0;
                end
            end
            BEAT0: begin
                if (xfer_s) begin
                    if (hold_mode_r) begin
                        pop_s = 1'b1;
                    end else begin
                        state_next_s    = BEAT1;
                        out_data_next_s = hi8(hold_y_r);
                        out_last_next_s = 1'b1;
                    end
                end else begin
                    state_next_s = BEAT0;
                end
            end
            BEAT1: begin
                if (xfer_s) begin
                    pop_s = 1'b1;
                end else begin
                    state_next_s = BEAT1;
                end
            end
            default: begin
                state_next_s     = IDLE;
                out_valid_next_s = 1'b0;
                out_last_next_s  = 1'b0;
            end
        endcase

        // A final beat either chains straight into the next queued sample or idles.
        if (pop_s) begin
            if (count_r > ONE_C) begin
                load_s   = 1'b1;
                load_y_s = mem_r[rd_ptr_r + PTR1_C];
            end else begin
                state_next_s     = IDLE;
                out_valid_next_s = 1'b0;
                out_last_next_s  = 1'b0;
            end
        end else begin
            load_y_s = load_y_s;
        end

        if (load_s) begin
            state_next_s     = BEAT0;
            hold_y_next_s    = load_y_s;
            hold_mode_next_s = bus.mode;
            out_valid_next_s = 1'b1;
            out_last_next_s  = bus.mode;
            out_data_next_s  = bus.mode ? sat8(load_y_s) : load_y_s[7:0];
        end else begin
            hold_y_next_s = hold_y_next_s;
        end
    end

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + ONE_C;
            2'b01:   count_next_s = count_r - ONE_C;
            default: count_next_s = count_r;
        endcase
    end

    // Sample storage; validity is tracked by the pointers, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.in_y_n;
        end
    end

    // Control, pointers, output registers and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            wr_ptr_r    <= {ADDR_W{1'b0}};
            rd_ptr_r    <= {ADDR_W{1'b0}};
            count_r     <= ZERO_C;
            hold_y_r    <= {Y_N_SIZE{1'b0}};
            hold_mode_r <= 1'b0;
            out_data_r  <= 8'h00;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            fifo_full_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            hold_y_r    <= hold_y_next_s;
            hold_mode_r <= hold_mode_next_s;
            out_data_r  <= out_data_next_s;
            out_valid_r <= out_valid_next_s;
            out_last_r  <= out_last_next_s;
            count_r     <= count_next_s;
            fifo_full_r <= (count_next_s == DEPTH_C);
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR1_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR1_C;
            end
            // A drop in the same cycle as a clear wins.
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (bus.clear_ovf) begin
                overflow_r <= 1'b0;
            end
        end
    end

    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_last  = out_last_r;
    assign bus.fifo_full = fifo_full_r;
    assign bus.overflow  = overflow_r;
endmodule
